// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// rtl/nibble_serial_adder_ctrl_pkg.sv - shared constants and state type for the nibble-serial adder
package nibble_serial_adder_ctrl_pkg;

    localparam int WIDTH   = 32;
    localparam int SLICE   = 4;
    localparam int NSLICES = WIDTH / SLICE;
    localparam int CNT_W   = $clog2(NSLICES);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/nibble_serial_adder_ctrl_rca.sv
// rtl/nibble_serial_adder_ctrl_rca.sv - 4-bit ripple-carry adder slice shared by the serial sequencer
module ripple_carry_adder
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout
);

    logic c;

    // Ripple the carry through one full adder per bit
    always_comb begin
        c = cin;
        s = '0;
        for (int i = 0; i < SLICE; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - 32-bit add sequenced one nibble per clock through a shared slice
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ovf
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic [SLICE-1:0]   slice_s;
    logic               slice_cout;
    logic [WIDTH-1:0]   sum_next;

    ripple_carry_adder u_slice (
        .a    (opa_q[SLICE-1:0]),
        .b    (opb_q[SLICE-1:0]),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // Newest nibble enters at the top so that after NSLICES shifts nibble 0 sits at the bottom
    assign sum_next = {slice_s, sum_q[WIDTH-1:SLICE]};

    // Next-state, shift/count and result-capture logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    opa_d   = A;
                    opb_d   = B;
                    carry_d = Cin;
                    a_msb_d = A[WIDTH-1];
                    b_msb_d = B[WIDTH-1];
                end
            end
            RUN: begin
                sum_d   = sum_next;
                carry_d = slice_cout;
                opa_d   = opa_q >> SLICE;
                opb_d   = opb_q >> SLICE;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NSLICES - 1)) begin
                    state_d = IDLE;
                    s_d     = sum_next;
                    cout_d  = slice_cout;
                    ovf_d   = (a_msb_q == b_msb_q) && (sum_next[WIDTH-1] != a_msb_q);
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight add
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign S    = s_q;
    assign Cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb/tb_nibble_serial_adder_ctrl.sv - randomized self-checking bench for the nibble-serial adder
module tb_nibble_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        Cin = 1'b0;
    logic        busy, done, Cout, ovf;
    logic [31:0] S;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct packed {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
    } result_t;

    nibble_serial_adder_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Cout  (Cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Reference: whole-word unsigned and signed arithmetic
    function automatic result_t ref_add(input logic [31:0] a, input logic [31:0] b, input logic cin);
        result_t r;
        logic [32:0] u;
        longint sg;
        u  = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        sg = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        r.s    = u[31:0];
        r.cout = u[32];
        r.ovf  = (sg > 64'sd2147483647) || (sg < -64'sd2147483648);
        return r;
    endfunction

    // done must never coincide with busy
    always @(negedge clk) begin
        if (rst_n && done) begin
            total_cnt++;
            if (busy !== 1'b0) $display("FAIL done_with_busy: busy=%0b required 0", busy);
            else pass_cnt++;
        end
    end

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic cin);
        A = a; B = b; Cin = cin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (done) begin cyc = n; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total_cnt++;
            if ({busy, done, S, Cout, ovf} !== 35'd0)
                $display("FAIL reset_idle: busy=%0b done=%0b S=%h Cout=%0b ovf=%0b required all 0", busy, done, S, Cout, ovf);
            else pass_cnt++;
        end
    endtask

    task automatic check_add(input string name, input logic [31:0] a, input logic [31:0] b, input logic cin);
        result_t e;
        int cyc;
        e = ref_add(a, b, cin);
        launch(a, b, cin);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL %s_busy: busy=%0b required 1", name, busy);
        else pass_cnt++;
        A = $urandom; B = $urandom; Cin = 1'($urandom);
        wait_done(cyc);
        total_cnt++;
        if (cyc != 8) $display("FAIL %s_latency: cycles=%0d required 8", name, cyc);
        else pass_cnt++;
        total_cnt++;
        if ({S, Cout, ovf} !== {e.s, e.cout, e.ovf})
            $display("FAIL %s_result: S=%h Cout=%0b ovf=%0b required S=%h Cout=%0b ovf=%0b", name, S, Cout, ovf, e.s, e.cout, e.ovf);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        check_add("basic", 32'h0000_0001, 32'h0000_0001, 1'b0);
    endtask

    task automatic test_carry();
        check_add("ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        check_add("ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    endtask

    task automatic test_busy_protect();
        int done_cnt = 0;
        int done_at = -1;
        launch(32'h1234_5678, 32'h1111_1111, 1'b0);
        for (int n = 1; n <= 14; n++) begin
            @(posedge clk); #1;
            if (done) begin done_cnt++; done_at = n; end
            A = $urandom; B = $urandom; Cin = 1'($urandom);
            start = (n == 2 || n == 4);
        end
        start = 1'b0;
        total_cnt++;
        if (done_cnt != 1 || done_at != 8)
            $display("FAIL busy_protect_done: count=%0d at=%0d required count=1 at=8", done_cnt, done_at);
        else pass_cnt++;
        total_cnt++;
        if (S !== 32'h2345_6789) $display("FAIL busy_protect_sum: S=%h required 23456789", S);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        result_t e1, e2;
        logic [31:0] a1, b1;
        int cyc;
        int held_bad = 0;
        a1 = $urandom; b1 = $urandom;
        e1 = ref_add(a1, b1, 1'b0);
        e2 = ref_add(32'h8000_0000, 32'h8000_0000, 1'b0);
        launch(a1, b1, 1'b0);
        wait_done(cyc);
        launch(32'h8000_0000, 32'h8000_0000, 1'b0);
        cyc = -1;
        for (int n = 1; n <= 20; n++) begin
            if (busy !== 1'b1 && n == 1) held_bad++;
            if ({S, Cout, ovf} !== {e1.s, e1.cout, e1.ovf}) held_bad++;
            @(posedge clk); #1;
            if (done) begin cyc = n; break; end
        end
        total_cnt++;
        if (held_bad != 0) $display("FAIL b2b_hold: bad_cycles=%0d required 0", held_bad);
        else pass_cnt++;
        total_cnt++;
        if (cyc != 8) $display("FAIL b2b_latency: cycles=%0d required 8", cyc);
        else pass_cnt++;
        total_cnt++;
        if ({S, Cout, ovf} !== {e2.s, e2.cout, e2.ovf})
            $display("FAIL b2b_result: S=%h Cout=%0b ovf=%0b required S=%h Cout=%0b ovf=%0b", S, Cout, ovf, e2.s, e2.cout, e2.ovf);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int done_cnt = 0;
        int bad = 0;
        launch(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({busy, done, S, Cout, ovf} !== 35'd0)
            $display("FAIL reset_mid_async: busy=%0b S=%h Cout=%0b ovf=%0b required all 0", busy, S, Cout, ovf);
        else pass_cnt++;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
            if ({busy, S, Cout, ovf} !== 34'd0) bad++;
        end
        total_cnt++;
        if (done_cnt != 0 || bad != 0)
            $display("FAIL reset_mid_quiet: dones=%0d bad_cycles=%0d required 0/0", done_cnt, bad);
        else pass_cnt++;
        check_add("after_reset", 32'd5, 32'd7, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            check_add("random", $urandom, $urandom, 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_busy_protect();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Multi-cycle sequencer that performs a 32-bit add using one shared 4-bit ripple_carry_adder slice. It processes one nibble per clock over 8 cycles and keeps the inter-slice carry in a register. It is the area-reduced alternative to the 32-bit chained-slice adder and presents a start/busy/done handshake to the surrounding datapath.

Parameters:
WIDTH, 32, operand and result width; must be a multiple of SLICE.
SLICE, 4, bits per adder slice; fixed by the 4-bit ripple_carry_adder.
NSLICES, WIDTH/SLICE (8), derived local constant; number of cycles per add.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request a new add; honoured only when busy=0.
A  input  32  operand A; sampled on the accepting edge only.
B  input  32  operand B; sampled on the accepting edge only.
Cin  input  1  carry-in; sampled on the accepting edge only.
busy  output  1  high while an add is in progress.
done  output  1  one-cycle pulse when S, Cout and ovf are newly valid.
S  output  32  registered sum; holds its value until the next completion.
Cout  output  1  registered carry out of bit 31.
ovf  output  1  registered signed overflow: (A[31]==B[31]) && (S[31]!=A[31]).

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, S=0, Cout=0, ovf=0. Slice counter, carry register and operand shift registers are cleared.
- Reset asserted mid-operation discards the in-flight add. No done pulse is produced for it.
- FSM states: IDLE and RUN.
- IDLE → RUN on a rising edge with start=1. That edge latches A and B into shift registers, Cin into the carry register, and clears the counter to 0. busy=1 from that edge.
- RUN, each edge:
  - The slice adds opA[3:0], opB[3:0] and the carry register.
  - The 4-bit sum shifts into the top of the working sum register; the slice carry-out loads the carry register.
  - opA and opB shift right by 4; the counter increments.
- RUN, final edge (counter==7):
  - Working sum (including the final nibble) copies to S; final carry copies to Cout; ovf is computed from the latched operand MSBs and the new S[31].
  - done=1 for exactly the next cycle; busy=0 from the same edge; state returns to IDLE.
- Latency: accepting edge E0, slices processed on E1..E8, done high in the cycle after E8. Throughput is one add per 8 cycles at best.
- start while busy=1 is ignored; no queuing.
- start=1 in the done cycle (busy=0) is accepted. done still pulses that cycle. S, Cout and ovf keep the just-completed result until the new add completes.
- A, B and Cin may change freely while busy=1; only the latched copies are used.
- Arithmetic is modulo 2^32. Cout is the unsigned carry and ovf the two's-complement overflow; both are reported, never saturated.
- done never asserts in the same cycle as busy.

Decomposition:
- Shared package/header: WIDTH, SLICE, NSLICES, the counter width (clog2 of NSLICES = 3) and state encodings IDLE=1'b0, RUN=1'b1.
- One natural sub-module: the existing 4-bit ripple_carry_adder, instantiated once as the shared slice.
- FSM, counter, shift registers and result registers live in this module.

Test Plan:
1. Reset then idle: hold rst_n=0 for 2 cycles, release, no start → busy=0, done=0, S=0, Cout=0, ovf=0 indefinitely.
2. Basic add: A=0x0000_0001, B=0x0000_0001, Cin=0, start for 1 cycle → done pulses exactly 8 cycles after the accepting edge; S=0x0000_0002, Cout=0, ovf=0.
3. Full carry ripple: A=0xFFFF_FFFF, B=0x0000_0000, Cin=1 → S=0x0000_0000, Cout=1, ovf=0. Then A=0x7FFF_FFFF, B=0x0000_0001, Cin=0 → S=0x8000_0000, Cout=0, ovf=1.
4. Busy protection: start add 0x1234_5678+0x1111_1111, then pulse start with different operands at cycles 3 and 5 while busy → single done, S=0x2345_6789. Operand inputs toggled mid-run do not affect the result.
5. Back-to-back: assert start in the done cycle with A=0x8000_0000, B=0x8000_0000 → the first result is held until the second done. Second result: S=0x0000_0000, Cout=1, ovf=1, done 8 cycles later.
6. Reset mid-operation: drop rst_n at cycle 4 of an add, release, wait 10 cycles → no done pulse, outputs 0. A subsequent add of 5+7 gives S=0x0000_000C.
